// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;

  localparam int unsigned CLKS_W_DEFAULT   = 16;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned MIN_CLKS_PER_BIT = 4;
  localparam int unsigned IDX_W            = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Plain-vector aliases of the state encoding for the receiver FSM
  localparam logic [1:0] ST_IDLE  = RX_IDLE;
  localparam logic [1:0] ST_START = RX_START;
  localparam logic [1:0] ST_DATA  = RX_DATA;
  localparam logic [1:0] ST_STOP  = RX_STOP;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx line plus one delayed copy for
// falling-edge detection. All flops reset to the idle (high) line level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic rx_prev_o
);

  logic s1_q, s2_q, s3_q;

  // Shift the raw line through the synchronizer and edge-detect stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rx_sync_o = s2_q;
  assign rx_prev_o = s3_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling, one-entry holding register with
// valid/read handshake, receive interrupt pulse and sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_W = CLKS_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_en_i,
  input  logic [CLKS_W-1:0]    clks_per_bit_i,
  input  logic                 rx_i,
  input  logic                 rd_i,
  input  logic                 err_clr_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 intr_rx_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam logic [CLKS_W-1:0] MIN_N = CLKS_W'(MIN_CLKS_PER_BIT);

  logic                 rx_sync, rx_prev;
  logic                 start_edge, sample;
  logic [CLKS_W-1:0]    n_in;

  logic [1:0]           state_q, state_d;
  logic [CLKS_W-1:0]    n_q, n_d;
  logic [CLKS_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic                 ferr_set_q, ferr_set_d;
  logic                 busy_q, busy_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 intr_q, intr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart_rx_sync u_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_i      (rx_i),
    .rx_sync_o (rx_sync),
    .rx_prev_o (rx_prev)
  );

  // Frame decoder: start detect, bit-centre counter, shift register
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    deliver_d  = 1'b0;
    ferr_set_d = 1'b0;
    n_in       = (clks_per_bit_i < MIN_N) ? MIN_N : clks_per_bit_i;
    start_edge = rx_prev & ~rx_sync;
    // The sample fires on the step where the counter would hit zero
    sample     = (cnt_q == CLKS_W'(1));

    if (!rx_en_i) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (start_edge) begin
        n_d     = n_in;
        cnt_d   = n_in >> 1;
        state_d = ST_START;
      end
    end else if (sample) begin
      cnt_d = n_q;
      case (state_q)
        ST_START: begin
          if (!rx_sync) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d[idx_q] = rx_sync;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
        end
        default: begin
          deliver_d  = rx_sync;
          ferr_set_d = ~rx_sync;
          state_d    = ST_IDLE;
        end
      endcase
    end else begin
      cnt_d = cnt_q - CLKS_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Holding register, handshake and sticky flags; a set beats a clear
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    intr_d  = 1'b0;
    ferr_d  = err_clr_i ? 1'b0 : ferr_q;
    ovr_d   = err_clr_i ? 1'b0 : ovr_q;

    if (deliver_q) begin
      if (!valid_q || rd_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        intr_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_i) begin
      valid_d = 1'b0;
    end

    if (ferr_set_q) ferr_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      n_q        <= MIN_N;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      deliver_q  <= 1'b0;
      ferr_set_q <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      intr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      deliver_q  <= deliver_d;
      ferr_set_q <= ferr_set_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      intr_q     <= intr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign intr_rx_o   = intr_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx. Expected bytes and delivery
// edges come from the frame timing rules: a byte whose line falls just
// before edge e0 is visible at edge e0 + 3 + N/2 + 9N.
module tb_uart_rx;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          rx_en_i;
  logic [CW-1:0] clks_per_bit_i;
  logic          rx_i;
  logic          rd_i;
  logic          err_clr_i;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o;
  logic          intr_rx_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          busy_o;

  int unsigned   cyc = 0;
  int unsigned   intr_cyc[$];
  int            tests = 0;
  int            fails = 0;

  uart_rx #(.CLKS_W(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .rx_en_i        (rx_en_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_i           (rx_i),
    .rd_i           (rd_i),
    .err_clr_i      (err_clr_i),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .intr_rx_o      (intr_rx_o),
    .frame_err_o    (frame_err_o),
    .overrun_o      (overrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge number X, cyc == X
  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle the interrupt is observed high
  always @(negedge clk) if (intr_rx_o === 1'b1) intr_cyc.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int unsigned deliver_edge(input int unsigned e0, input int unsigned n);
    return e0 + 3 + n / 2 + 9 * n;
  endfunction

  // Drive up to ncyc cycles of an 8N1 frame; rd_i is raised only at rd_edge
  task automatic send_frame(input logic [7:0] b, input int unsigned n, input logic stop,
                            input int unsigned ncyc, input int unsigned rd_edge,
                            output int unsigned e0);
    logic [7:0] byte_v;
    int unsigned k;
    byte_v = b;
    e0 = cyc + 1;
    for (int unsigned c = 0; c < ncyc; c++) begin
      k = c / n;
      if (k == 0)      rx_i = 1'b0;
      else if (k <= 8) rx_i = byte_v[k-1];
      else             rx_i = stop;
      rd_i = (cyc + 1 == rd_edge);
      tick(1);
    end
    rd_i = 1'b0;
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] b, input int unsigned exp_edge);
    check({tag, "_nintr"}, 32'(intr_cyc.size()), 32'd1);
    check({tag, "_edge"}, 32'(intr_cyc.size() > 0 ? intr_cyc[0] : 0), exp_edge);
    check({tag, "_data"}, 32'(rx_data_o), 32'(b));
    check({tag, "_valid"}, 32'(rx_valid_o), 32'd1);
    intr_cyc.delete();
  endtask

  task automatic read_pop();
    rd_i = 1'b1;
    tick(1);
    rd_i = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    int unsigned n;
    int unsigned rd_edge;
    logic [7:0]  b;

    rst_ni = 1'b0; rx_en_i = 1'b1; rx_i = 1'b1; rd_i = 1'b0; err_clr_i = 1'b0;
    clks_per_bit_i = 16'd16;
    tick(4);
    rst_ni = 1'b1;
    tick(2);

    // Reset state
    check("rst_data",  32'(rx_data_o),   32'd0);
    check("rst_valid", 32'(rx_valid_o),  32'd0);
    check("rst_intr",  32'(intr_rx_o),   32'd0);
    check("rst_ferr",  32'(frame_err_o), 32'd0);
    check("rst_ovr",   32'(overrun_o),   32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);

    // Clean 0xA5 at N=16, delivered at edge e0+155; read clears valid
    send_frame(8'hA5, 16, 1'b1, 160, 0, e0);
    tick(4);
    check("a5_edge155", deliver_edge(e0, 16) - e0, 32'd155);
    expect_rx("a5", 8'hA5, deliver_edge(e0, 16));
    check("a5_busy", 32'(busy_o), 32'd0);
    read_pop();
    check("a5_rd_valid", 32'(rx_valid_o), 32'd0);

    // 0.4-bit glitch: start sample sees high, back to idle silently
    tick(3);
    rx_i = 1'b0;
    tick(6);
    check("glitch_busy", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    tick(5);
    check("glitch_idle", 32'(busy_o), 32'd0);
    tick(200);
    check("glitch_nintr", 32'(intr_cyc.size()), 32'd0);
    check("glitch_valid", 32'(rx_valid_o), 32'd0);
    check("glitch_ferr",  32'(frame_err_o), 32'd0);
    check("glitch_ovr",   32'(overrun_o),   32'd0);

    // Stop bit low: framing error, byte dropped, held-low line is not a start
    send_frame(8'h3C, 16, 1'b0, 160, 0, e0);
    tick(10);
    check("ferr_set",   32'(frame_err_o), 32'd1);
    check("ferr_valid", 32'(rx_valid_o),  32'd0);
    check("ferr_nintr", 32'(intr_cyc.size()), 32'd0);
    tick(200);
    check("ferr_low_busy",  32'(busy_o), 32'd0);
    check("ferr_low_nintr", 32'(intr_cyc.size()), 32'd0);
    rx_i = 1'b1;
    tick(4);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("ferr_clr", 32'(frame_err_o), 32'd0);

    // Overrun at N=8: 0x11 kept, 0x22 dropped, no second interrupt
    clks_per_bit_i = 16'd8;
    tick(3);
    send_frame(8'h11, 8, 1'b1, 80, 0, e0);
    tick(4);
    expect_rx("ovr_first", 8'h11, deliver_edge(e0, 8));
    tick(3);
    send_frame(8'h22, 8, 1'b1, 80, 0, e0);
    tick(4);
    check("ovr_data",  32'(rx_data_o),  32'h11);
    check("ovr_flag",  32'(overrun_o),  32'd1);
    check("ovr_valid", 32'(rx_valid_o), 32'd1);
    check("ovr_nintr", 32'(intr_cyc.size()), 32'd0);
    rd_i = 1'b1; err_clr_i = 1'b1;
    tick(1);
    rd_i = 1'b0; err_clr_i = 1'b0;
    check("ovr_clr",   32'(overrun_o),  32'd0);
    check("ovr_pop",   32'(rx_valid_o), 32'd0);

    // Read coincident with delivery: new byte loads, no overrun
    tick(3);
    send_frame(8'h11, 8, 1'b1, 80, 0, e0);
    tick(4);
    expect_rx("coin_first", 8'h11, deliver_edge(e0, 8));
    tick(3);
    rd_edge = deliver_edge(cyc + 1, 8);
    send_frame(8'h22, 8, 1'b1, 80, rd_edge, e0);
    tick(4);
    expect_rx("coin", 8'h22, deliver_edge(e0, 8));
    check("coin_ovr", 32'(overrun_o), 32'd0);
    read_pop();

    // Divisor below the minimum acts as N=4
    clks_per_bit_i = 16'd2;
    tick(3);
    send_frame(8'hFF, 4, 1'b1, 40, 0, e0);
    tick(4);
    expect_rx("n2", 8'hFF, deliver_edge(e0, 4));
    read_pop();

    // Disable mid-data aborts the frame; later frame still decodes
    clks_per_bit_i = 16'd8;
    tick(3);
    send_frame(8'h99, 8, 1'b1, 30, 0, e0);
    rx_en_i = 1'b0;
    tick(1);
    check("en_abort_busy", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    tick(20);
    rx_en_i = 1'b1;
    tick(2);
    check("en_nintr", 32'(intr_cyc.size()), 32'd0);
    check("en_valid", 32'(rx_valid_o), 32'd0);
    send_frame(8'h5A, 8, 1'b1, 80, 0, e0);
    tick(4);
    expect_rx("en_5a", 8'h5A, deliver_edge(e0, 8));

    // Reset mid-frame with valid and frame error set beforehand
    send_frame(8'h3C, 8, 1'b0, 80, 0, e0);
    rx_i = 1'b1;
    tick(10);
    check("prerst_ferr", 32'(frame_err_o), 32'd1);
    send_frame(8'hC3, 8, 1'b1, 40, 0, e0);
    rst_ni = 1'b0;
    tick(1);
    check("mrst_data",  32'(rx_data_o),   32'd0);
    check("mrst_valid", 32'(rx_valid_o),  32'd0);
    check("mrst_intr",  32'(intr_rx_o),   32'd0);
    check("mrst_ferr",  32'(frame_err_o), 32'd0);
    check("mrst_ovr",   32'(overrun_o),   32'd0);
    check("mrst_busy",  32'(busy_o),      32'd0);
    rst_ni = 1'b1;
    rx_i = 1'b1;
    tick(4);
    intr_cyc.delete();

    // Randomized bytes and divisors
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(4, 20);
      b = 8'($urandom);
      clks_per_bit_i = CW'(n);
      tick($urandom_range(1, 6));
      send_frame(b, n, 1'b1, 10 * n, 0, e0);
      tick(4);
      expect_rx($sformatf("rnd%0d", i), b, deliver_edge(e0, n));
      read_pop();
      check($sformatf("rnd%0d_pop", i), 32'(rx_valid_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
